// File: rtl/cosim_commit_checker.sv
// In-order commit-log checker: buffers multi-port DUT register writes and golden
// reference writes, pops one pair per cycle, and counts/captures matches and mismatches.
module cosim_commit_checker #(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned Depth          = 16,
    parameter int unsigned KeyW           = 64,
    parameter int unsigned ValW           = 128,
    parameter int unsigned XregW          = 64,
    parameter int unsigned CntW           = 32,
    parameter bit          HaltOnMismatch = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic [NumPorts-1:0]           dut_valid_i,
    input  logic [NumPorts*KeyW-1:0]      dut_key_i,
    input  logic [NumPorts*ValW-1:0]      dut_value_i,
    output logic                          dut_ready_o,
    input  logic                          ref_valid_i,
    input  logic [KeyW-1:0]               ref_key_i,
    input  logic [ValW-1:0]               ref_value_i,
    output logic                          ref_ready_o,
    output logic                          mismatch_o,
    output logic                          halted_o,
    output logic [CntW-1:0]               match_cnt_o,
    output logic [CntW-1:0]               mismatch_cnt_o,
    output logic [KeyW-1:0]               mm_dut_key_o,
    output logic [KeyW-1:0]               mm_ref_key_o,
    output logic [ValW-1:0]               mm_dut_value_o,
    output logic [ValW-1:0]               mm_ref_value_o,
    output logic [$clog2(Depth+1)-1:0]    dut_level_o,
    output logic [$clog2(Depth+1)-1:0]    ref_level_o
);

    localparam int unsigned LvlW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    typedef struct packed {
        logic [KeyW-1:0] key;
        logic [ValW-1:0] value;
    } entry_t;

    typedef enum logic {StRun, StHalt} state_e;

    entry_t          dut_mem_q [Depth];
    entry_t          dut_mem_d [Depth];
    entry_t          ref_mem_q [Depth];
    entry_t          ref_mem_d [Depth];
    logic [PtrW-1:0] dut_wr_q, dut_wr_d, dut_rd_q, dut_rd_d;
    logic [PtrW-1:0] ref_wr_q, ref_wr_d, ref_rd_q, ref_rd_d;
    logic [LvlW-1:0] dut_level_q, dut_level_d, ref_level_q, ref_level_d;
    state_e          state_q, state_d;
    logic            mismatch_q, mismatch_d;
    entry_t          mm_dut_q, mm_dut_d, mm_ref_q, mm_ref_d;
    logic [CntW-1:0] match_cnt_q, match_cnt_d, mismatch_cnt_q, mismatch_cnt_d;

    logic            dut_ready, ref_ready, ref_push, fire, is_match;
    entry_t          dut_head, ref_head;
    int unsigned     dut_slots;

    // Modulo-Depth pointer advance; Depth need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= Depth) begin
            s = s - Depth;
        end
        return PtrW'(s);
    endfunction

    // Readiness reflects occupancy at cycle start; no same-cycle pop bypass.
    assign dut_ready = !rst_i && !clear_i && ((Depth - 32'(dut_level_q)) >= NumPorts);
    assign ref_ready = !rst_i && !clear_i && (32'(ref_level_q) < Depth);

    always_comb begin
        dut_mem_d      = dut_mem_q;
        ref_mem_d      = ref_mem_q;
        dut_wr_d       = dut_wr_q;
        dut_rd_d       = dut_rd_q;
        ref_wr_d       = ref_wr_q;
        ref_rd_d       = ref_rd_q;
        state_d        = state_q;
        mismatch_d     = mismatch_q;
        mm_dut_d       = mm_dut_q;
        mm_ref_d       = mm_ref_q;
        match_cnt_d    = match_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        dut_slots      = 0;

        ref_push = ref_valid_i && ref_ready;
        fire     = (state_q == StRun) && (dut_level_q != '0) && (ref_level_q != '0) && !clear_i;
        dut_head = dut_mem_q[dut_rd_q];
        ref_head = ref_mem_q[ref_rd_q];

        // XREG keys only carry XregW meaningful value bits.
        if (ref_head.key[3:0] == 4'b0000) begin
            is_match = (dut_head.key == ref_head.key) &&
                       (dut_head.value[XregW-1:0] == ref_head.value[XregW-1:0]);
        end else begin
            is_match = (dut_head.key == ref_head.key) && (dut_head.value == ref_head.value);
        end

        // Compact valid ports into consecutive slots, lowest port first.
        if (dut_ready) begin
            for (int unsigned p = 0; p < NumPorts; p++) begin
                if (dut_valid_i[p]) begin
                    dut_mem_d[ptr_add(dut_wr_q, dut_slots)] =
                        '{key: dut_key_i[p*KeyW +: KeyW], value: dut_value_i[p*ValW +: ValW]};
                    dut_slots++;
                end
            end
        end
        dut_wr_d = ptr_add(dut_wr_q, dut_slots);

        if (ref_push) begin
            ref_mem_d[ref_wr_q] = '{key: ref_key_i, value: ref_value_i};
            ref_wr_d            = ptr_add(ref_wr_q, 32'd1);
        end

        if (fire) begin
            dut_rd_d = ptr_add(dut_rd_q, 32'd1);
            ref_rd_d = ptr_add(ref_rd_q, 32'd1);
            if (is_match) begin
                if (match_cnt_q != '1) begin
                    match_cnt_d = match_cnt_q + CntW'(1);
                end
            end else begin
                if (mismatch_cnt_q != '1) begin
                    mismatch_cnt_d = mismatch_cnt_q + CntW'(1);
                end
                if (!mismatch_q) begin
                    mm_dut_d   = dut_head;
                    mm_ref_d   = ref_head;
                    mismatch_d = 1'b1;
                end
                if (HaltOnMismatch) begin
                    state_d = StHalt;
                end
            end
        end

        dut_level_d = LvlW'(32'(dut_level_q) + dut_slots - 32'(fire));
        ref_level_d = LvlW'(32'(ref_level_q) + 32'(ref_push) - 32'(fire));

        // Clear flushes buffers and the capture but keeps the counters.
        if (clear_i) begin
            dut_wr_d    = '0;
            dut_rd_d    = '0;
            ref_wr_d    = '0;
            ref_rd_d    = '0;
            dut_level_d = '0;
            ref_level_d = '0;
            state_d     = StRun;
            mismatch_d  = 1'b0;
            mm_dut_d    = '0;
            mm_ref_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dut_wr_q       <= '0;
            dut_rd_q       <= '0;
            ref_wr_q       <= '0;
            ref_rd_q       <= '0;
            dut_level_q    <= '0;
            ref_level_q    <= '0;
            state_q        <= StRun;
            mismatch_q     <= 1'b0;
            mm_dut_q       <= '0;
            mm_ref_q       <= '0;
            match_cnt_q    <= '0;
            mismatch_cnt_q <= '0;
        end else begin
            dut_wr_q       <= dut_wr_d;
            dut_rd_q       <= dut_rd_d;
            ref_wr_q       <= ref_wr_d;
            ref_rd_q       <= ref_rd_d;
            dut_level_q    <= dut_level_d;
            ref_level_q    <= ref_level_d;
            state_q        <= state_d;
            mismatch_q     <= mismatch_d;
            mm_dut_q       <= mm_dut_d;
            mm_ref_q       <= mm_ref_d;
            match_cnt_q    <= match_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
        end
    end

    // Storage needs no reset: only slots below the level are ever read out.
    always_ff @(posedge clk_i) begin
        dut_mem_q <= dut_mem_d;
        ref_mem_q <= ref_mem_d;
    end

    assign dut_ready_o    = dut_ready;
    assign ref_ready_o    = ref_ready;
    assign mismatch_o     = mismatch_q;
    assign halted_o       = (state_q == StHalt);
    assign match_cnt_o    = match_cnt_q;
    assign mismatch_cnt_o = mismatch_cnt_q;
    assign mm_dut_key_o   = mm_dut_q.key;
    assign mm_dut_value_o = mm_dut_q.value;
    assign mm_ref_key_o   = mm_ref_q.key;
    assign mm_ref_value_o = mm_ref_q.value;
    assign dut_level_o    = dut_level_q;
    assign ref_level_o    = ref_level_q;

endmodule

// File: tb/tb_cosim_commit_checker.sv
// Bench for cosim_commit_checker: a halt-mode and a continue-mode (4-bit counter)
// instance share stimulus and are checked every cycle against a queue-based model.
module tb_cosim_commit_checker;

    localparam int NP    = 2;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [63:0]  key;
        logic [127:0] value;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic [1:0]   dut_valid = '0;
    logic [127:0] dut_key = '0;
    logic [255:0] dut_value = '0;
    logic         ref_valid = 1'b0;
    logic [63:0]  ref_key = '0;
    logic [127:0] ref_value = '0;

    logic         dr0, rr0, mm0, h0, dr1, rr1, mm1, h1;
    logic [31:0]  mc0, mmc0;
    logic [3:0]   mc1, mmc1;
    logic [63:0]  mdk0, mrk0, mdk1, mrk1;
    logic [127:0] mdv0, mrv0, mdv1, mrv1;
    logic [4:0]   dl0, rl0, dl1, rl1;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cosim_commit_checker #(.NumPorts(2), .Depth(16), .KeyW(64), .ValW(128), .XregW(64),
                           .CntW(32), .HaltOnMismatch(1'b1)) dut0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .dut_valid_i(dut_valid), .dut_key_i(dut_key), .dut_value_i(dut_value), .dut_ready_o(dr0),
        .ref_valid_i(ref_valid), .ref_key_i(ref_key), .ref_value_i(ref_value), .ref_ready_o(rr0),
        .mismatch_o(mm0), .halted_o(h0), .match_cnt_o(mc0), .mismatch_cnt_o(mmc0),
        .mm_dut_key_o(mdk0), .mm_ref_key_o(mrk0), .mm_dut_value_o(mdv0), .mm_ref_value_o(mrv0),
        .dut_level_o(dl0), .ref_level_o(rl0));

    cosim_commit_checker #(.NumPorts(2), .Depth(16), .KeyW(64), .ValW(128), .XregW(64),
                           .CntW(4), .HaltOnMismatch(1'b0)) dut1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .dut_valid_i(dut_valid), .dut_key_i(dut_key), .dut_value_i(dut_value), .dut_ready_o(dr1),
        .ref_valid_i(ref_valid), .ref_key_i(ref_key), .ref_value_i(ref_value), .ref_ready_o(rr1),
        .mismatch_o(mm1), .halted_o(h1), .match_cnt_o(mc1), .mismatch_cnt_o(mmc1),
        .mm_dut_key_o(mdk1), .mm_ref_key_o(mrk1), .mm_dut_value_o(mdv1), .mm_ref_value_o(mrv1),
        .dut_level_o(dl1), .ref_level_o(rl1));

    // Reference model: FIFOs as queues, per-instance result state.
    ent_t        mdq [2][$];
    ent_t        mrq [2][$];
    logic [31:0] m_mc [2];
    logic [31:0] m_mmc [2];
    bit          m_flag [2];
    bit          m_halt [2];
    ent_t        m_mmd [2];
    ent_t        m_mmr [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_mc[i] = 0; m_mmc[i] = 0; m_flag[i] = 0; m_halt[i] = 0;
            m_mmd[i] = '0; m_mmr[i] = '0;
        end
    end

    function automatic bit m_dready(input int i);
        return !rst && !clear && ((DEPTH - mdq[i].size()) >= NP);
    endfunction

    function automatic bit m_rready(input int i);
        return !rst && !clear && (mrq[i].size() < DEPTH);
    endfunction

    task automatic model_step(input int i);
        ent_t        d, r, e;
        bit          fire, eq, dok, rok;
        logic [31:0] cmax;
        cmax = (i == 0) ? 32'hffff_ffff : 32'h0000_000f;
        if (rst) begin
            mdq[i].delete(); mrq[i].delete();
            m_mc[i] = 0; m_mmc[i] = 0; m_flag[i] = 0; m_halt[i] = 0;
            m_mmd[i] = '0; m_mmr[i] = '0;
        end else if (clear) begin
            mdq[i].delete(); mrq[i].delete();
            m_flag[i] = 0; m_halt[i] = 0; m_mmd[i] = '0; m_mmr[i] = '0;
        end else begin
            dok  = m_dready(i);
            rok  = m_rready(i);
            fire = !m_halt[i] && (mdq[i].size() > 0) && (mrq[i].size() > 0);
            if (dok) begin
                for (int p = 0; p < NP; p++) begin
                    if (dut_valid[p]) begin
                        e.key = dut_key[p*64 +: 64];
                        e.value = dut_value[p*128 +: 128];
                        mdq[i].push_back(e);
                    end
                end
            end
            if (ref_valid && rok) begin
                e.key = ref_key;
                e.value = ref_value;
                mrq[i].push_back(e);
            end
            if (fire) begin
                d = mdq[i].pop_front();
                r = mrq[i].pop_front();
                if (r.key[3:0] == 4'h0) eq = (d.key == r.key) && (d.value[63:0] == r.value[63:0]);
                else                    eq = (d.key == r.key) && (d.value == r.value);
                if (eq) begin
                    if (m_mc[i] != cmax) m_mc[i] = m_mc[i] + 1;
                end else begin
                    if (m_mmc[i] != cmax) m_mmc[i] = m_mmc[i] + 1;
                    if (!m_flag[i]) begin
                        m_mmd[i] = d; m_mmr[i] = r; m_flag[i] = 1;
                    end
                    if (i == 0) m_halt[i] = 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic chk(input string nm, input int i, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[inst%0d]: got %0h expected %0h", nm, i, act, exp);
    endtask

    task automatic cmp(input int i, input logic dr, input logic rr, input logic mm, input logic h,
                       input logic [31:0] mc, input logic [31:0] mmc,
                       input logic [63:0] dk, input logic [63:0] rk,
                       input logic [127:0] dv, input logic [127:0] rv,
                       input logic [4:0] dl, input logic [4:0] rl);
        chk("dut_ready", i, 128'(dr), 128'(m_dready(i)));
        chk("ref_ready", i, 128'(rr), 128'(m_rready(i)));
        chk("mismatch", i, 128'(mm), 128'(m_flag[i]));
        chk("halted", i, 128'(h), 128'(m_halt[i]));
        chk("match_cnt", i, 128'(mc), 128'(m_mc[i]));
        chk("mismatch_cnt", i, 128'(mmc), 128'(m_mmc[i]));
        chk("mm_dut_key", i, 128'(dk), 128'(m_mmd[i].key));
        chk("mm_ref_key", i, 128'(rk), 128'(m_mmr[i].key));
        chk("mm_dut_value", i, dv, m_mmd[i].value);
        chk("mm_ref_value", i, rv, m_mmr[i].value);
        chk("dut_level", i, 128'(dl), 128'(mdq[i].size()));
        chk("ref_level", i, 128'(rl), 128'(mrq[i].size()));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, dr0, rr0, mm0, h0, mc0, mmc0, mdk0, mrk0, mdv0, mrv0, dl0, rl0);
            cmp(1, dr1, rr1, mm1, h1, 32'(mc1), 32'(mmc1), mdk1, mrk1, mdv1, mrv1, dl1, rl1);
        end
    end

    // Stimulus helpers: inputs change 1 time unit after the active edge.
    task automatic cyc(input logic [1:0] v, input ent_t e0, input ent_t e1,
                       input logic rv, input ent_t r, input logic cl, input logic rs);
        dut_valid = v;
        dut_key   = {e1.key, e0.key};
        dut_value = {e1.value, e0.value};
        ref_valid = rv;
        ref_key   = r.key;
        ref_value = r.value;
        clear     = cl;
        rst       = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(2'b00, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(2'b00, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle(1);
    endtask

    function automatic ent_t mk(input int unsigned n, input logic [3:0] ty);
        ent_t e;
        e.key   = {60'(n), ty};
        e.value = {32'(n * 32'h9E37_79B9), 32'(n ^ 32'hA5A5_5A5A), 32'(n + 7), 32'(n * 13)};
        return e;
    endfunction

    initial begin
        ent_t ea [8];
        ent_t a, b, bad2, bad5, junk;
        int unsigned nd, nr, k, bit_idx;
        logic [1:0] v;
        ent_t e0, e1, r;
        logic rvb, cl, rs, acc_d, acc_r;

        // Reset state
        cyc(2'b00, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        cyc(2'b00, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_dut_ready_low", 0, 128'(dr0), 128'(0));
        chk("rst_ref_ready_low", 0, 128'(rr0), 128'(0));
        idle(1);
        @(negedge clk);
        chk("post_rst_dut_ready", 0, 128'(dr0), 128'(1));
        chk("post_rst_ref_ready", 1, 128'(rr1), 128'(1));
        chk("post_rst_match", 0, 128'(mc0), 128'(0));

        // Eight matching XREG entries: DUT two per cycle, ref one per cycle
        for (int n = 0; n < 8; n++) begin
            ea[n] = mk(32'(n + 100), 4'h0);
            ea[n].value = {$urandom, $urandom, $urandom, $urandom};
        end
        for (int c = 0; c < 8; c++) begin
            if (c < 4) cyc(2'b11, ea[2*c], ea[2*c+1], 1'b1, ea[c], 1'b0, 1'b0);
            else       cyc(2'b00, '0, '0, 1'b1, ea[c], 1'b0, 1'b0);
        end
        idle(10);
        @(negedge clk);
        chk("burst_match_cnt", 0, 128'(mc0), 128'(8));
        chk("burst_match_cnt", 1, 128'(mc1), 128'(8));
        chk("burst_mismatch_cnt", 0, 128'(mmc0), 128'(0));
        chk("burst_dut_level", 0, 128'(dl0), 128'(0));
        chk("burst_ref_level", 0, 128'(rl0), 128'(0));

        // Compaction: only port 1 valid
        do_reset();
        junk.key = 64'hdead; junk.value = 128'h1234;
        a.key = 64'h20; a.value = 128'h5;
        cyc(2'b10, junk, a, 1'b1, a, 1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        chk("compact_match_cnt", 0, 128'(mc0), 128'(1));
        chk("compact_mismatch_cnt", 0, 128'(mmc0), 128'(0));
        chk("compact_dut_level", 0, 128'(dl0), 128'(0));

        // XREG masks value bits above 63; FREG compares all bits
        do_reset();
        a.key = 64'h50; a.value = 128'h1_0000_0000_0000_0007;
        b.key = 64'h50; b.value = 128'h7;
        cyc(2'b01, a, '0, 1'b1, b, 1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        chk("xreg_match_cnt", 0, 128'(mc0), 128'(1));
        chk("xreg_mismatch", 0, 128'(mm0), 128'(0));
        a.key = 64'h51; b.key = 64'h51;
        cyc(2'b01, a, '0, 1'b1, b, 1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        chk("freg_mismatch_cnt", 0, 128'(mmc0), 128'(1));
        chk("freg_match_cnt", 0, 128'(mc0), 128'(1));
        chk("freg_halted", 0, 128'(h0), 128'(1));
        chk("freg_halted", 1, 128'(h1), 128'(0));

        // Halt on third entry, then fill the DUT FIFO, then clear
        do_reset();
        for (int n = 0; n < 8; n++) ea[n] = mk(32'(n + 200), 4'h1);
        bad2 = ea[2]; bad2.value[0] = ~bad2.value[0];
        cyc(2'b11, ea[0], ea[1], 1'b1, ea[0], 1'b0, 1'b0);
        cyc(2'b11, ea[2], ea[3], 1'b1, ea[1], 1'b0, 1'b0);
        cyc(2'b00, '0, '0, 1'b1, bad2, 1'b0, 1'b0);
        idle(4);
        @(negedge clk);
        chk("halt_mismatch", 0, 128'(mm0), 128'(1));
        chk("halt_halted", 0, 128'(h0), 128'(1));
        chk("halt_match_cnt", 0, 128'(mc0), 128'(2));
        chk("halt_mm_dut_key", 0, 128'(mdk0), 128'(ea[2].key));
        chk("halt_mm_dut_value", 0, mdv0, ea[2].value);
        chk("halt_mm_ref_value", 0, mrv0, bad2.value);
        cyc(2'b01, ea[4], '0, 1'b0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) cyc(2'b11, ea[5], ea[6], 1'b0, '0, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        chk("fill_dut_level", 0, 128'(dl0), 128'(16));
        chk("fill_dut_ready", 0, 128'(dr0), 128'(0));
        cyc(2'b00, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        chk("clear_dut_level", 0, 128'(dl0), 128'(0));
        chk("clear_halted", 0, 128'(h0), 128'(0));
        chk("clear_mismatch", 0, 128'(mm0), 128'(0));
        chk("clear_match_cnt", 0, 128'(mc0), 128'(2));

        // Continue mode: mismatches at entries 2 and 5, capture keeps entry 2
        do_reset();
        for (int n = 0; n < 8; n++) ea[n] = mk(32'(n + 300), 4'h2);
        bad2 = ea[2]; bad2.value[100] = ~bad2.value[100];
        bad5 = ea[5]; bad5.value[3] = ~bad5.value[3];
        cyc(2'b11, ea[0], ea[1], 1'b1, ea[0], 1'b0, 1'b0);
        cyc(2'b11, ea[2], ea[3], 1'b1, ea[1], 1'b0, 1'b0);
        cyc(2'b11, ea[4], ea[5], 1'b1, bad2, 1'b0, 1'b0);
        cyc(2'b00, '0, '0, 1'b1, ea[3], 1'b0, 1'b0);
        cyc(2'b00, '0, '0, 1'b1, ea[4], 1'b0, 1'b0);
        cyc(2'b00, '0, '0, 1'b1, bad5, 1'b0, 1'b0);
        idle(5);
        @(negedge clk);
        chk("cont_mismatch_cnt", 1, 128'(mmc1), 128'(2));
        chk("cont_match_cnt", 1, 128'(mc1), 128'(4));
        chk("cont_mm_ref_value", 1, mrv1, bad2.value);
        chk("cont_mm_dut_value", 1, mdv1, ea[2].value);
        chk("cont_halt_inst_mismatch_cnt", 0, 128'(mmc0), 128'(1));

        // Backpressure on the ref FIFO, then reset mid-stream
        do_reset();
        for (int n = 0; n < 16; n++) cyc(2'b00, '0, '0, 1'b1, mk(32'(n + 400), 4'h1), 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        chk("bp_ref_level", 0, 128'(rl0), 128'(16));
        chk("bp_ref_ready", 0, 128'(rr0), 128'(0));
        cyc(2'b01, mk(32'd400, 4'h1), '0, 1'b1, mk(32'd999, 4'h1), 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        chk("bp_ref_level_after_pop", 0, 128'(rl0), 128'(15));
        chk("bp_match_cnt", 0, 128'(mc0), 128'(1));
        cyc(2'b11, ea[0], ea[1], 1'b1, ea[0], 1'b0, 1'b0);
        cyc(2'b11, ea[2], ea[3], 1'b1, ea[1], 1'b0, 1'b1);
        @(negedge clk);
        chk("midrst_dut_ready", 0, 128'(dr0), 128'(0));
        chk("midrst_ref_ready", 0, 128'(rr0), 128'(0));
        chk("midrst_dut_level", 0, 128'(dl0), 128'(0));
        chk("midrst_ref_level", 0, 128'(rl0), 128'(0));
        chk("midrst_match_cnt", 0, 128'(mc0), 128'(0));
        chk("midrst_mm_ref_key", 0, 128'(mrk0), 128'(0));
        idle(1);

        // Randomized traffic, source follows the continue-mode instance's acceptance
        nd = 0; nr = 0;
        for (int c = 0; c < 4000; c++) begin
            cl  = ($urandom_range(0, 149) == 0);
            rs  = ($urandom_range(0, 699) == 0);
            v   = 2'($urandom_range(0, 3));
            rvb = (((c / 300) % 2) == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
            k   = nd;
            e0  = v[0] ? mk(k, 4'(k % 3)) : junk;
            if (v[0]) k = k + 1;
            e1  = mk(k, 4'(k % 3));
            r   = mk(nr, 4'(nr % 3));
            if ($urandom_range(0, 24) == 0) begin
                bit_idx = $urandom_range(0, 127);
                r.value[bit_idx] = ~r.value[bit_idx];
            end
            if ($urandom_range(0, 49) == 0) r.key[4] = ~r.key[4];
            acc_d = !rs && !cl && ((DEPTH - mdq[1].size()) >= NP);
            acc_r = !rs && !cl && (mrq[1].size() < DEPTH);
            cyc(v, e0, e1, rvb, r, cl, rs);
            if (rs || cl) begin
                nd = 0; nr = 0;
            end else begin
                if (acc_d) nd = nd + 32'($countones(v));
                if (acc_r && rvb) nr = nr + 1;
            end
        end
        idle(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cosim_commit_checker.md
Name: cosim_commit_checker

Overview:
Synthesizable, parametrised commit-log checker for the cosim flow. The DUT side pushes up to NumPorts register-write log entries per cycle, and the testbench pushes golden entries from the spike step, one per cycle. Both streams are buffered in FIFOs, compared in order, and the result is reported as match/mismatch counters plus a first-mismatch capture. It is the hardware successor to the package-level reg-write log compare, generalised to multi-retire cores, configurable widths and halt/continue mode.

Parameters:
NumPorts, 2, DUT retire ports per cycle (1..4)
Depth, 16, entries per FIFO; Depth >= NumPorts
KeyW, 64, width of reg key {id, type[3:0]}
ValW, 128, width of stored value (FREG_W)
XregW, 64, compared value width for XREG keys (type 4'b0000)
CntW, 32, counter width
HaltOnMismatch, 1, 1: stop comparing after the first mismatch; 0: keep comparing

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
clear_i  in  1  flush both FIFOs, clear mismatch capture/flag, return to RUN
dut_valid_i  in  NumPorts  per-port entry valid
dut_key_i  in  NumPorts*KeyW  per-port key, port p at [p*KeyW +: KeyW]
dut_value_i  in  NumPorts*ValW  per-port value
dut_ready_o  out  1  DUT FIFO free slots >= NumPorts
ref_valid_i  in  1  golden entry valid
ref_key_i  in  KeyW  golden key
ref_value_i  in  ValW  golden value
ref_ready_o  out  1  ref FIFO not full
mismatch_o  out  1  sticky: a mismatch has occurred since reset/clear
halted_o  out  1  FSM in HALT
match_cnt_o  out  CntW  compared-equal entries
mismatch_cnt_o  out  CntW  compared-unequal entries
mm_dut_key_o / mm_ref_key_o  out  KeyW  keys of the first mismatch
mm_dut_value_o / mm_ref_value_o  out  ValW  values of the first mismatch
dut_level_o / ref_level_o  out  $clog2(Depth+1)  FIFO occupancy

Behaviour:
- Reset (rst_i high at the edge): FIFOs empty, FSM=RUN, all counters/captures/flags 0. Ready outputs are forced 0 while rst_i is high and go to 1 on the first cycle after reset. Reset mid-operation discards all buffered entries.
- DUT push: the push is all-or-nothing. When dut_ready_o is high, every port with dut_valid_i set is written in the same cycle. Valid ports are compacted in ascending port order and gaps are skipped. With valid=4'b0101, port0 goes to slot n and port2 to slot n+1. When dut_ready_o is low, nothing is taken and the source holds.
- Ref push: one entry is written when ref_valid_i && ref_ready_o.
- Compare fires when FSM=RUN and both FIFOs are non-empty. One head is popped from each FIFO in that cycle. Results register at that edge and are visible the next cycle.
- Equality test: the keys must match in full. If key[3:0]==4'b0000 (XREG), only value[XregW-1:0] is compared. Otherwise all ValW bits are compared.
- Match: match_cnt_o increments.
- Mismatch: mismatch_cnt_o increments. If mismatch_o was 0, the mm_* outputs capture both entries and mismatch_o is set. If mismatch_o was already 1, the mm_* outputs are unchanged.
- FSM: RUN -> HALT on a mismatch when HaltOnMismatch=1. In HALT, no pops occur, FIFOs keep filling and backpressure when full. HALT -> RUN only on clear_i. With HaltOnMismatch=0 the FSM never leaves RUN.
- Simultaneous push and pop on the same FIFO is legal; level = level + pushed - popped, and a full FIFO popping this cycle still reports ready from the level at cycle start (no bypass).
- clear_i priority: clear_i beats push and compare. Ready outputs are 0 while clear_i is high. Counters are preserved; only FIFOs, FSM, mismatch_o and mm_* are cleared.
- Counters saturate at all-ones and never wrap.
- FIFO pointers wrap modulo Depth; Depth need not be a power of two.

Test Plan:
- Reset then 8 matching entries, DUT valid=2'b11 each cycle and ref one per cycle -> match_cnt_o=8, mismatch_cnt_o=0, both levels 0 after all pops.
- Compaction: DUT valid=2'b10 with key 0x20 and value 0x5, ref key 0x20 value 0x5 -> match_cnt_o=1, no slot gap, dut_level_o back to 0.
- XREG mask: key 0x50 (type 0), DUT value 0x1_00000000_00000007 vs ref 0x7 -> match. Same values with key 0x51 (FREG) -> mismatch.
- HaltOnMismatch=1: third entry value differs -> mismatch_o=1, halted_o=1, mm_* hold the third pair, match_cnt_o=2. Further pushes fill DUT FIFO to 16 and dut_ready_o=0. clear_i -> levels 0, halted_o=0, match_cnt_o still 2.
- HaltOnMismatch=0: two mismatches at entries 2 and 5 -> mismatch_cnt_o=2, mm_* hold entry 2.
- Backpressure: push 16 ref entries with no DUT traffic -> ref_ready_o=0 at level 16. One DUT push plus ref push in the same cycle -> ref push rejected, level 15 next cycle. Assert rst_i mid-stream -> all outputs 0.
